// File: rtl/mcpu_core_intctl.sv
// mcpu_core_intctl: interrupt controller that syncs, latches, masks and prioritises external lines for the core
// Ports: clkrst_core_clk/clkrst_core_rst_n clock and async active-low reset; irq_lines external requests;
// interrupts_enabled global enable; int_ack core took the exception; cfg_we/cfg_addr/cfg_wdata/cfg_rdata
// register port (0 MASK, 1 EDGE, 2 PENDING, 3 ACTIVE/EOI); int_pending/int_type registered request to the core.
module mcpu_core_intctl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clkrst_core_clk,
  input  logic               clkrst_core_rst_n,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic               interrupts_enabled,
  input  logic               int_ack,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               int_pending,
  output logic [3:0]         int_type
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t r_state;
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
  logic [NUM_IRQ-1:0] r_prev, r_mask, r_edge, r_pend;
  logic [3:0] r_active_id, r_int_type;
  logic r_busy, r_int_pending;
  logic [NUM_IRQ-1:0] w_sync, w_cand, w_clr, w_to_edge, w_pend_nxt, w_wdata;
  logic [15:0] w_cand16, w_type_oh;
  logic [3:0] w_win;
  logic w_ack, w_eoi, w_unused;
  assign w_unused    = ^cfg_wdata;
  assign w_wdata     = cfg_wdata[NUM_IRQ-1:0];
  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_cand      = r_pend & r_mask;
  assign w_cand16    = 16'(w_cand);
  assign w_type_oh   = 16'h1 << r_int_type;
  assign w_ack       = r_state == REQ && int_ack;
  assign w_eoi       = cfg_we && cfg_addr == 2'd3;
  assign w_clr       = (cfg_we && cfg_addr == 2'd2 ? w_wdata : '0) | (w_ack ? w_type_oh[NUM_IRQ-1:0] : '0);
  // a line switching from level to edge starts with a clean pending bit
  assign w_to_edge   = cfg_we && cfg_addr == 2'd1 ? w_wdata & ~r_edge : '0;
  // edge lines: a new rising edge beats any clear in the same cycle; level lines mirror the synced input
  assign w_pend_nxt  = ((r_edge & ((w_sync & ~r_prev) | (r_pend & ~w_clr))) | (~r_edge & w_sync)) & ~w_to_edge;
  assign cfg_rdata   = cfg_addr == 2'd0 ? 32'(r_mask) :
                       cfg_addr == 2'd1 ? 32'(r_edge) :
                       cfg_addr == 2'd2 ? 32'(r_pend) : {r_busy, 27'b0, r_active_id};
  assign int_pending = r_int_pending;
  assign int_type    = r_int_type;
  // lowest set index wins
  always_comb begin
    w_win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (w_cand[i]) w_win = 4'(i);
  end
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      r_sync <= '0;
      r_prev <= '0;
      r_mask <= '0;
      r_edge <= '0;
      r_pend <= '0;
    end else begin
      if (SYNC_STAGES > 1) r_sync <= {r_sync[SYNC_STAGES-2:0], irq_lines};
      r_prev <= w_sync;
      r_pend <= w_pend_nxt;
      if (cfg_we && cfg_addr == 2'd0) r_mask <= w_wdata;
      if (cfg_we && cfg_addr == 2'd1) r_edge <= w_wdata;
    end
  end
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      r_state       <= IDLE;
      r_int_pending <= 1'b0;
      r_int_type    <= '0;
      r_active_id   <= '0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (interrupts_enabled && |w_cand) begin
          r_state       <= REQ;
          r_int_pending <= 1'b1;
          r_int_type    <= w_win;
        end
        REQ: if (int_ack) begin
          r_state       <= SERVICE;
          r_active_id   <= r_int_type;
          r_busy        <= 1'b1;
          r_int_pending <= 1'b0;
        end else if (!interrupts_enabled || !w_cand16[r_int_type]) begin
          r_state       <= IDLE;
          r_int_pending <= 1'b0;
        end
        SERVICE: if (w_eoi) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcpu_core_intctl.sv
// tb_mcpu_core_intctl: directed plus random checks of mcpu_core_intctl against a behavioural model
module tb_mcpu_core_intctl;
  localparam int N = 8;
  localparam int S = 2;
  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] irq = '0;
  logic ie = 1'b0, ack = 1'b0, we = 1'b0;
  logic [1:0] addr = '0;
  logic [31:0] wdata = '0, rdata, v;
  logic ip;
  logic [3:0] it;
  int n_asrt = 0, n_fail = 0;
  logic [N-1:0] g_irq = '0;
  logic g_ie = 1'b0;
  logic [N-1:0] m_mask, m_edge, m_pend;
  logic [N-1:0] h[0:3];
  int m_state;
  logic m_ip, m_busy;
  logic [3:0] m_it, m_aid;
  mcpu_core_intctl #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n), .irq_lines(irq),
    .interrupts_enabled(ie), .int_ack(ack), .cfg_we(we), .cfg_addr(addr),
    .cfg_wdata(wdata), .cfg_rdata(rdata), .int_pending(ip), .int_type(it));
  always #10 clk = ~clk;
  task automatic model_reset();
    m_mask = '0; m_edge = '0; m_pend = '0;
    for (int j = 0; j < 4; j++) h[j] = '0;
    m_state = M_IDLE; m_ip = 0; m_busy = 0; m_it = 0; m_aid = 0;
  endtask
  // one clock of the controller, computed from the pre-edge state and the applied inputs
  task automatic model_edge();
    logic [N-1:0] sy, pv, cand, np;
    int win;
    bit clr;
    sy = h[S-1];
    pv = h[S];
    cand = m_pend & m_mask;
    win = -1;
    for (int i = N - 1; i >= 0; i--) if (cand[i]) win = i;
    for (int i = 0; i < N; i++) begin
      if (m_edge[i]) begin
        clr = (we && addr == 2 && wdata[i]) || (m_state == M_REQ && ack && m_it == 4'(i));
        np[i] = (sy[i] && !pv[i]) ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
      end else np[i] = sy[i];
      if (we && addr == 1 && wdata[i] && !m_edge[i]) np[i] = 1'b0;
    end
    if (m_state == M_IDLE) begin
      if (ie && win >= 0) begin m_state = M_REQ; m_ip = 1; m_it = 4'(win); end
    end else if (m_state == M_REQ) begin
      if (ack) begin m_state = M_SVC; m_aid = m_it; m_busy = 1; m_ip = 0; end
      else if (!ie || !cand[m_it]) begin m_state = M_IDLE; m_ip = 0; end
    end else if (we && addr == 3) begin m_state = M_IDLE; m_busy = 0; end
    if (we && addr == 0) m_mask = wdata[N-1:0];
    if (we && addr == 1) m_edge = wdata[N-1:0];
    m_pend = np;
    for (int j = 3; j > 0; j--) h[j] = h[j-1];
    h[0] = irq;
  endtask
  always @(posedge clk) if (!rst_n) model_reset(); else model_edge();
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] r);
    addr = a;
    #1 r = rdata;
  endtask
  task automatic check_all();
    chk("int_pending", 32'(ip), 32'(m_ip));
    chk("int_type", 32'(it), 32'(m_it));
    rd(0, v); chk("MASK", v, 32'(m_mask));
    rd(1, v); chk("EDGE", v, 32'(m_edge));
    rd(2, v); chk("PENDING", v, 32'(m_pend));
    rd(3, v); chk("ACTIVE", v, {m_busy, 27'b0, m_aid});
  endtask
  task automatic cyc(input logic [N-1:0] l, input logic e, input logic a, input logic w,
                     input logic [1:0] ad, input logic [31:0] d);
    irq = l; ie = e; ack = a; we = w; addr = ad; wdata = d;
    @(negedge clk);
    check_all();
  endtask
  task automatic tick(); cyc(g_irq, g_ie, 0, 0, 0, 0); endtask
  task automatic ticks(input int n); for (int k = 0; k < n; k++) tick(); endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d); cyc(g_irq, g_ie, 0, 1, a, d); endtask
  task automatic ackp(); cyc(g_irq, g_ie, 1, 0, 0, 0); endtask
  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    tick();
    rst_n = 1'b1;
    // single edge interrupt on line 3
    wr(0, 32'h08); wr(1, 32'h08);
    g_ie = 1; g_irq = 8'h08; tick();
    g_irq = 0; ticks(2);
    rd(2, v); chk("t1_pend_set", v, 32'h08);
    chk("t1_ip_early", 32'(ip), 0);
    tick();
    chk("t1_ip", 32'(ip), 1); chk("t1_type", 32'(it), 3);
    ackp();
    chk("t1_ack_ip", 32'(ip), 0);
    rd(2, v); chk("t1_ack_pend", v, 0);
    rd(3, v); chk("t1_active", v, 32'h80000003);
    wr(3, 0);
    rd(3, v); chk("t1_eoi", v, 32'h00000003);
    // priority and freeze with level lines 5 and 2
    wr(1, 0); wr(0, 32'hFF);
    g_irq = 8'h24; ticks(4);
    chk("t2_ip", 32'(ip), 1); chk("t2_type", 32'(it), 2);
    g_irq = 8'h25; ticks(4);
    chk("t2_frozen", 32'(it), 2);
    ackp();
    chk("t2_ack_ip", 32'(ip), 0);
    wr(3, 0); tick();
    chk("t2_reissue_ip", 32'(ip), 1); chk("t2_reissue_type", 32'(it), 0);
    // global disable withdraw and reissue
    g_ie = 0; tick();
    chk("t3_withdraw_ip", 32'(ip), 0);
    rd(2, v); chk("t3_pend_kept", v, 32'h25);
    g_ie = 1; tick();
    chk("t3_again_ip", 32'(ip), 1); chk("t3_again_type", 32'(it), 0);
    ackp(); g_irq = 0; ticks(4); wr(3, 0); ticks(2);
    chk("t3_quiet", 32'(ip), 0);
    // same-cycle set and W1C on edge line 1
    g_ie = 0; wr(0, 0); wr(1, 32'h02);
    g_irq = 8'h02; ticks(2);
    wr(2, 32'h02);
    rd(2, v); chk("t4_set_wins", v, 32'h02);
    wr(2, 32'h02);
    rd(2, v); chk("t4_w1c", v, 0);
    g_irq = 0;
    // masking and ignore rules
    wr(1, 0); wr(0, 0);
    g_irq = 8'hFF; g_ie = 1; ticks(4);
    rd(2, v); chk("t5_pend_all", v, 32'hFF);
    chk("t5_masked", 32'(ip), 0);
    ackp();
    chk("t5_ack_idle", 32'(ip), 0);
    rd(3, v); chk("t5_not_busy", 32'(v[31]), 0);
    wr(3, 0);
    chk("t5_eoi_idle", 32'(ip), 0);
    // asynchronous reset while requesting
    wr(0, 32'hFF); tick();
    chk("t6_req", 32'(ip), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_ip", 32'(ip), 0); chk("t6_rst_type", 32'(it), 0);
    for (int a = 0; a < 4; a++) begin rd(2'(a), v); chk("t6_rst_reg", v, 0); end
    tick();
    rst_n = 1'b1;
    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom % 6 == 0) g_irq = N'($urandom);
      g_ie = ($urandom % 8) != 0;
      cyc(g_irq, g_ie, $urandom % 4 == 0, $urandom % 3 == 0, 2'($urandom), $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
